l1_victim_refill_ctrl: RTL and testbench
========================================

# l1_victim_refill_ctrl

Miss-side companion to the L1 victim cache. The victim cache is a lookup/insert responder; this block is the initiator that drives it. On an L1 miss it probes the victim cache, then refills the L1 from a victim-cache hit or from memory. It writes back the displaced L1 line if it is dirty, then inserts that line, clean, into the victim cache. Sits between the L1 cache controller, the victim cache, and the memory port.

## Interface
Parameters:
- TAG_CHECK_CYC, 1, cycles between probe assertion and victim-cache result sampling (fixed by victim-cache registered valid)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- l1_req_i  in  cpu_req_type  miss request; `valid`, `addr` (line address)
- l1_victim_i  in  evict_data_type  line the L1 displaces; `valid` = 0 means no eviction
- l1_res_o  out  evict_data_type  refill line to L1; `valid` pulse for one cycle
- busy_o  out  1  high from request accept until the cycle after the `l1_res_o` pulse
- vc_req_o  out  cpu_req_type  probe to victim cache
- vc_res_i  in  evict_data_type  victim-cache lookup result (`valid` = hit)
- vc_miss_i  in  1  victim-cache miss flag
- vc_evict_o  out  evict_data_type  insert to victim cache; one-cycle `valid` pulse
- mem_req_o  out  mem_req_type  `valid`, `rw` (1 = write), `addr`, `data` (128-bit line)
- mem_data_i  in  mem_data_type  `ready`, `data`
- no_probe_o  out  32  probes issued
- no_vc_hit_o  out  32  victim-cache hits
- no_wb_o  out  32  dirty write-backs

## Operation
States: IDLE, PROBE, CHECK, MEM_RD, WB, INSERT, RESPOND.

- **IDLE**
  - Accept when `l1_req_i.valid` is high: latch the miss address and the full `l1_victim_i` into registers.
  - Go to PROBE and increment `no_probe_o`.
  - Request inputs are ignored in every other state.
- **PROBE**
  - `vc_req_o.valid` = 1 and `vc_req_o.addr` = latched miss address.
  - Go to CHECK.
- **CHECK**
  - `vc_req_o` is held unchanged and `vc_res_i` is sampled.
  - Hit (`vc_res_i.valid` = 1 and `vc_miss_i` = 0): latch the data and dirty bit, increment `no_vc_hit_o`, go to WB if the victim is valid and dirty, otherwise INSERT.
  - Otherwise go to MEM_RD.
- **MEM_RD**
  - Drive `mem_req_o.valid` = 1, `rw` = 0, `addr` = miss address until `mem_data_i.ready` is high.
  - On ready: latch the data with dirty = 0, then go to WB if the victim is dirty, otherwise INSERT.
- **WB**
  - Drive `mem_req_o.valid` = 1, `rw` = 1, `addr`/`data` = latched victim until ready.
  - On ready: increment `no_wb_o` and go to INSERT.
- **INSERT**
  - If the latched victim is valid: `vc_evict_o.valid` = 1 with the victim addr and data, `dirty` forced to 0.
  - If not valid: no pulse.
  - Go to RESPOND.
- **RESPOND**
  - `l1_res_o.valid` = 1 with the latched data, the latched dirty bit, and the miss address.
  - Go to IDLE.

Policy: the victim cache only ever holds clean lines, so it may overwrite any entry without write-back.

Boundary conditions:
- Victim invalid: skip WB and INSERT (pass through INSERT with no pulse).
- `mem_data_i.ready` high in the first cycle of MEM_RD or WB: completes that cycle.
- `mem_data_i.ready` never asserted: the block stalls indefinitely. No timeout.
- Reset mid-operation: return to IDLE and discard latched state and any in-flight memory transaction. The memory side must tolerate an abandoned request.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - state = IDLE
  - all `valid` outputs = 0
  - `mem_req_o`, `vc_req_o`, `vc_evict_o`, `l1_res_o` fields = 0
  - `busy_o` = 0
  - counters = 0
- All outputs are decoded from registered state and registered data. No input-to-output combinational path, except `vc_req_o` held constant across PROBE and CHECK.
- Latency from accept cycle (IDLE with `valid` high) to the `l1_res_o` pulse:
  - VC hit, clean or no victim: 4 cycles (PROBE, CHECK, INSERT, RESPOND).
  - VC miss, clean victim: 4 + N_rd cycles, where N_rd is the number of MEM_RD cycles including the ready cycle.
  - Dirty victim: add N_wb cycles.
- The `vc_evict_o` pulse precedes `l1_res_o.valid` by exactly 1 cycle.
- Back-to-back misses: IDLE costs 1 cycle between requests.

## Structure
- Add a state enum `vrc_state_type` to package `cache_def`.
- Reuse the existing `cpu_req_type`, `evict_data_type`, `mem_req_type`, `mem_data_type` and `cache_data_type`. Add no new types.
- Counters instantiate the existing `adder_32bit`, one per counter.
- No other sub-module. One FSM plus data registers in a single file.

## Test plan
1. **VC hit, no victim**
   - Stimulus: miss addr 0x0000_1040, victim invalid, VC returns hit with data 0xA5…A5 in CHECK.
   - Response: `l1_res_o.valid` 4 cycles after accept with data A5…A5; no `mem_req_o.valid`; no `vc_evict_o` pulse; `no_vc_hit_o` = 1.
2. **VC miss, clean victim**
   - Stimulus: miss addr 0x2000, victim addr 0x3000 clean, memory ready after 3 cycles.
   - Response: one read to 0x2000; then `vc_evict_o` addr 0x3000 with dirty = 0; then `l1_res_o` on the following cycle.
3. **VC miss, dirty victim**
   - Stimulus: as scenario 2 but victim dirty with data 0x1234…
   - Response: read to 0x2000, then write of 0x1234… to 0x3000, then insert with dirty = 0; `no_wb_o` = 1.
4. **Zero-wait memory**
   - Stimulus: ready held high.
   - Response: MEM_RD and WB each take 1 cycle; total latency 6 cycles for a dirty victim.
5. **Reset mid-WB**
   - Stimulus: assert `rst_i` during WB.
   - Response: all outputs 0 asynchronously; counters 0; the next request is accepted normally.
6. **Request during busy**
   - Stimulus: second `l1_req_i.valid` while in MEM_RD.
   - Response: ignored; only one probe is counted.

Source files
------------

// File: rtl/cache_def.sv
// Shared cache types for the L1, the victim cache and the memory port, plus
// the state encoding of the miss-side refill controller.
package cache_def;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic           valid;
    logic           dirty;
    logic [31:0]    addr;
    cache_data_type data;
  } evict_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    CHECK,
    MEM_RD,
    WB,
    INSERT,
    RESPOND
  } vrc_state_type;

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit adder. The carry out is dropped, so the sum wraps modulo 2^32.
module adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/l1_victim_refill_ctrl.sv
// Miss-side initiator for the L1 victim cache: probes the victim cache, refills
// the L1 from a hit or from memory, writes back a dirty victim, then inserts it clean.
module l1_victim_refill_ctrl
  import cache_def::*;
#(
  parameter int TAG_CHECK_CYC = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  cpu_req_type    l1_req_i,
  input  evict_data_type l1_victim_i,
  output evict_data_type l1_res_o,
  output logic           busy_o,
  output cpu_req_type    vc_req_o,
  input  evict_data_type vc_res_i,
  input  logic           vc_miss_i,
  output evict_data_type vc_evict_o,
  output mem_req_type    mem_req_o,
  input  mem_data_type   mem_data_i,
  output logic [31:0]    no_probe_o,
  output logic [31:0]    no_vc_hit_o,
  output logic [31:0]    no_wb_o
);

  localparam logic [3:0] CHK_LAST = 4'(TAG_CHECK_CYC - 1);

  vrc_state_type  state_q, state_d;
  logic [31:0]    miss_addr_q, miss_addr_d;
  evict_data_type victim_q, victim_d;
  cache_data_type data_q, data_d;
  logic           dirty_q, dirty_d;
  logic [3:0]     chk_cnt_q, chk_cnt_d;

  logic           probe_inc, hit_inc, wb_inc;
  logic [31:0]    probe_q, probe_d, probe_sum;
  logic [31:0]    hit_q, hit_d, hit_sum;
  logic [31:0]    wb_q, wb_d, wb_sum;

  logic           vc_hit;
  logic           victim_dirty;
  logic           unused_vc_addr;

  assign vc_hit         = vc_res_i.valid && !vc_miss_i;
  assign victim_dirty   = victim_q.valid && victim_q.dirty;
  // The victim cache answers for the address we probed, so its echo is not needed.
  assign unused_vc_addr = ^vc_res_i.addr;

  adder_32bit u_probe_add (.a_i(probe_q), .b_i(32'd1), .sum_o(probe_sum));
  adder_32bit u_hit_add   (.a_i(hit_q),   .b_i(32'd1), .sum_o(hit_sum));
  adder_32bit u_wb_add    (.a_i(wb_q),    .b_i(32'd1), .sum_o(wb_sum));

  assign probe_d = probe_inc ? probe_sum : probe_q;
  assign hit_d   = hit_inc   ? hit_sum   : hit_q;
  assign wb_d    = wb_inc    ? wb_sum    : wb_q;

  // NOTE: every register uses non-blocking assignment so all flops update from
  // the same pre-edge values regardless of statement order.
  // NOTE: the line-wide data registers are reset too: a reset mid-miss must not
  // leak a stale line or victim into the next transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      victim_q    <= '0;
      data_q      <= '0;
      dirty_q     <= 1'b0;
      chk_cnt_q   <= '0;
      probe_q     <= '0;
      hit_q       <= '0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      victim_q    <= victim_d;
      data_q      <= data_d;
      dirty_q     <= dirty_d;
      chk_cnt_q   <= chk_cnt_d;
      probe_q     <= probe_d;
      hit_q       <= hit_d;
      wb_q        <= wb_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    victim_d    = victim_q;
    data_d      = data_q;
    dirty_d     = dirty_q;
    chk_cnt_d   = chk_cnt_q;
    probe_inc   = 1'b0;
    hit_inc     = 1'b0;
    wb_inc      = 1'b0;
    l1_res_o    = '0;
    vc_req_o    = '0;
    vc_evict_o  = '0;
    mem_req_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (l1_req_i.valid) begin
          miss_addr_d = l1_req_i.addr;
          victim_d    = l1_victim_i;
          probe_inc   = 1'b1;
          state_d     = PROBE;
        end
      end
      PROBE: begin
        vc_req_o.valid = 1'b1;
        vc_req_o.addr  = miss_addr_q;
        chk_cnt_d      = '0;
        state_d        = CHECK;
      end
      CHECK: begin
        vc_req_o.valid = 1'b1;
        vc_req_o.addr  = miss_addr_q;
        if (chk_cnt_q == CHK_LAST) begin
          if (vc_hit) begin
            data_d  = vc_res_i.data;
            dirty_d = vc_res_i.dirty;
            hit_inc = 1'b1;
            state_d = victim_dirty ? WB : INSERT;
          end else begin
            state_d = MEM_RD;
          end
        end else begin
          chk_cnt_d = chk_cnt_q + 4'd1;
        end
      end
      MEM_RD: begin
        mem_req_o.valid = 1'b1;
        mem_req_o.addr  = miss_addr_q;
        if (mem_data_i.ready) begin
          data_d  = mem_data_i.data;
          dirty_d = 1'b0;
          state_d = victim_dirty ? WB : INSERT;
        end
      end
      WB: begin
        mem_req_o.valid = 1'b1;
        mem_req_o.rw    = 1'b1;
        mem_req_o.addr  = victim_q.addr;
        mem_req_o.data  = victim_q.data;
        if (mem_data_i.ready) begin
          wb_inc  = 1'b1;
          state_d = INSERT;
        end
      end
      INSERT: begin
        // The victim cache holds only clean lines, so it can drop entries freely.
        if (victim_q.valid) begin
          vc_evict_o       = victim_q;
          vc_evict_o.dirty = 1'b0;
        end
        state_d = RESPOND;
      end
      RESPOND: begin
        l1_res_o.valid = 1'b1;
        l1_res_o.dirty = dirty_q;
        l1_res_o.addr  = miss_addr_q;
        l1_res_o.data  = data_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign no_probe_o  = probe_q;
  assign no_vc_hit_o = hit_q;
  assign no_wb_o     = wb_q;

endmodule

// File: tb/tb_l1_victim_refill_ctrl.sv
// Directed bench for l1_victim_refill_ctrl: VC hit, VC miss with clean and dirty
// victims, zero-wait memory, reset mid write-back and a request while busy.
module tb_l1_victim_refill_ctrl;
  import cache_def::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  cpu_req_type    l1_req_i;
  evict_data_type l1_victim_i;
  evict_data_type l1_res_o;
  logic           busy_o;
  cpu_req_type    vc_req_o;
  evict_data_type vc_res_i;
  logic           vc_miss_i;
  evict_data_type vc_evict_o;
  mem_req_type    mem_req_o;
  mem_data_type   mem_data_i;
  logic [31:0]    no_probe_o, no_vc_hit_o, no_wb_o;

  int total = 0;
  int bad   = 0;

  cache_data_type d_a5, d_55, d_dd, d_12, d_77, d_c3;

  l1_victim_refill_ctrl #(.TAG_CHECK_CYC(1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .l1_req_i    (l1_req_i),
    .l1_victim_i (l1_victim_i),
    .l1_res_o    (l1_res_o),
    .busy_o      (busy_o),
    .vc_req_o    (vc_req_o),
    .vc_res_i    (vc_res_i),
    .vc_miss_i   (vc_miss_i),
    .vc_evict_o  (vc_evict_o),
    .mem_req_o   (mem_req_o),
    .mem_data_i  (mem_data_i),
    .no_probe_o  (no_probe_o),
    .no_vc_hit_o (no_vc_hit_o),
    .no_wb_o     (no_wb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic request(input logic [31:0] addr, input logic v_valid, input logic v_dirty,
                         input logic [31:0] v_addr, input cache_data_type v_data);
    l1_req_i.valid    = 1'b1;
    l1_req_i.addr     = addr;
    l1_victim_i.valid = v_valid;
    l1_victim_i.dirty = v_dirty;
    l1_victim_i.addr  = v_addr;
    l1_victim_i.data  = v_data;
    tick();
    l1_req_i = '0;
  endtask

  task automatic vc_answer(input logic hit, input cache_data_type data);
    vc_res_i.valid = hit;
    vc_res_i.dirty = 1'b0;
    vc_res_i.addr  = '0;
    vc_res_i.data  = data;
    vc_miss_i      = ~hit;
  endtask

  initial begin
    d_a5 = {16{8'hA5}};
    d_55 = {16{8'h55}};
    d_dd = {4{32'hDEAD_BEEF}};
    d_12 = {4{32'h1234_5678}};
    d_77 = {16{8'h77}};
    d_c3 = {16{8'hC3}};

    rst_i       = 1'b1;
    l1_req_i    = '0;
    l1_victim_i = '0;
    vc_res_i    = '0;
    vc_miss_i   = 1'b0;
    mem_data_i  = '0;
    #12;
    check("rst_l1_res", l1_res_o, '0);
    check("rst_vc_req", vc_req_o, '0);
    check("rst_vc_evict", vc_evict_o, '0);
    check("rst_mem_req", mem_req_o, '0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", {no_probe_o, no_vc_hit_o, no_wb_o}, '0);
    tick();
    rst_i = 1'b0;

    // 1: VC hit, no victim -> response 4 cycles after accept
    request(32'h0000_1040, 1'b0, 1'b0, 32'h0, '0);
    check("s1_probe_valid", vc_req_o.valid, 1);
    check("s1_probe_addr", vc_req_o.addr, 32'h0000_1040);
    check("s1_busy", busy_o, 1);
    check("s1_no_probe", no_probe_o, 1);
    vc_answer(1'b1, d_a5);
    tick();
    check("s1_check_hold", {vc_req_o.valid, vc_req_o.addr}, {1'b1, 32'h0000_1040});
    check("s1_no_mem_chk", mem_req_o.valid, 0);
    tick();
    vc_answer(1'b0, '0);
    vc_miss_i = 1'b0;
    check("s1_no_evict", vc_evict_o.valid, 0);
    check("s1_no_mem_ins", mem_req_o.valid, 0);
    check("s1_hits", no_vc_hit_o, 1);
    check("s1_vc_req_off", vc_req_o.valid, 0);
    tick();
    check("s1_res_valid", l1_res_o.valid, 1);
    check("s1_res_data", l1_res_o.data, d_a5);
    check("s1_res_addr", l1_res_o.addr, 32'h0000_1040);
    check("s1_res_dirty", l1_res_o.dirty, 0);
    tick();
    check("s1_res_pulse", l1_res_o.valid, 0);
    check("s1_idle_busy", busy_o, 0);

    // 2: VC miss, clean victim, ready in third MEM_RD cycle; 6: request while busy
    vc_answer(1'b0, '0);
    request(32'h0000_2000, 1'b1, 1'b0, 32'h0000_3000, d_55);
    tick();
    tick();
    check("s2_rd_valid", {mem_req_o.valid, mem_req_o.rw}, {1'b1, 1'b0});
    check("s2_rd_addr", mem_req_o.addr, 32'h0000_2000);
    check("s2_no_evict_rd", vc_evict_o.valid, 0);
    l1_req_i.valid = 1'b1;
    l1_req_i.addr  = 32'h0000_9000;
    tick();
    l1_req_i = '0;
    check("s6_ignored_probe", no_probe_o, 2);
    check("s6_rd_addr_kept", mem_req_o.addr, 32'h0000_2000);
    tick();
    check("s2_rd_3rd", mem_req_o.valid, 1);
    mem_data_i.ready = 1'b1;
    mem_data_i.data  = d_dd;
    tick();
    mem_data_i = '0;
    check("s2_mem_done", mem_req_o.valid, 0);
    check("s2_evict", {vc_evict_o.valid, vc_evict_o.dirty, vc_evict_o.addr},
          {1'b1, 1'b0, 32'h0000_3000});
    check("s2_evict_data", vc_evict_o.data, d_55);
    check("s2_no_res_yet", l1_res_o.valid, 0);
    tick();
    check("s2_evict_pulse", vc_evict_o.valid, 0);
    check("s2_res", {l1_res_o.valid, l1_res_o.dirty, l1_res_o.addr},
          {1'b1, 1'b0, 32'h0000_2000});
    check("s2_res_data", l1_res_o.data, d_dd);
    tick();
    check("s2_no_wb", no_wb_o, 0);

    // 3: VC miss, dirty victim -> read, write-back, clean insert
    request(32'h0000_2000, 1'b1, 1'b1, 32'h0000_3000, d_12);
    tick();
    tick();
    tick();
    tick();
    mem_data_i.ready = 1'b1;
    mem_data_i.data  = d_77;
    tick();
    mem_data_i = '0;
    check("s3_wb_req", {mem_req_o.valid, mem_req_o.rw, mem_req_o.addr},
          {1'b1, 1'b1, 32'h0000_3000});
    check("s3_wb_data", mem_req_o.data, d_12);
    check("s3_wb_no_evict", vc_evict_o.valid, 0);
    tick();
    check("s3_wb_stall", mem_req_o.valid, 1);
    mem_data_i.ready = 1'b1;
    tick();
    mem_data_i = '0;
    check("s3_no_wb", no_wb_o, 1);
    check("s3_evict", {vc_evict_o.valid, vc_evict_o.dirty, vc_evict_o.addr},
          {1'b1, 1'b0, 32'h0000_3000});
    check("s3_evict_data", vc_evict_o.data, d_12);
    tick();
    check("s3_res", {l1_res_o.valid, l1_res_o.dirty}, {1'b1, 1'b0});
    check("s3_res_data", l1_res_o.data, d_77);
    tick();

    // 4: zero-wait memory, dirty victim -> 6-cycle latency
    mem_data_i.ready = 1'b1;
    mem_data_i.data  = d_c3;
    request(32'h0000_0400, 1'b1, 1'b1, 32'h0000_0800, d_55);
    tick();
    tick();
    check("s4_rd", {mem_req_o.valid, mem_req_o.rw}, {1'b1, 1'b0});
    tick();
    check("s4_wb", {mem_req_o.valid, mem_req_o.rw, mem_req_o.addr},
          {1'b1, 1'b1, 32'h0000_0800});
    tick();
    check("s4_evict", vc_evict_o.valid, 1);
    check("s4_no_res_yet", l1_res_o.valid, 0);
    tick();
    check("s4_res_at6", {l1_res_o.valid, l1_res_o.addr}, {1'b1, 32'h0000_0400});
    check("s4_cnts", {no_probe_o, no_vc_hit_o, no_wb_o}, {32'd4, 32'd1, 32'd2});
    tick();
    mem_data_i = '0;

    // 5: reset during WB, then a normal request
    vc_answer(1'b1, d_a5);
    request(32'h0000_4000, 1'b1, 1'b1, 32'h0000_5000, d_12);
    tick();
    tick();
    check("s5_in_wb", {mem_req_o.valid, mem_req_o.rw, mem_req_o.addr},
          {1'b1, 1'b1, 32'h0000_5000});
    check("s5_pre_hits", no_vc_hit_o, 2);
    rst_i = 1'b1;
    #1;
    check("s5_rst_mem", mem_req_o, '0);
    check("s5_rst_vc_req", vc_req_o, '0);
    check("s5_rst_evict", vc_evict_o, '0);
    check("s5_rst_res", l1_res_o, '0);
    check("s5_rst_busy", busy_o, 0);
    check("s5_rst_cnt", {no_probe_o, no_vc_hit_o, no_wb_o}, '0);
    tick();
    rst_i = 1'b0;
    vc_answer(1'b1, d_c3);
    request(32'h0000_6000, 1'b0, 1'b0, 32'h0, '0);
    check("s5_probe", {vc_req_o.valid, vc_req_o.addr}, {1'b1, 32'h0000_6000});
    check("s5_no_probe", no_probe_o, 1);
    tick();
    tick();
    vc_answer(1'b0, '0);
    check("s5_no_mem", mem_req_o.valid, 0);
    check("s5_no_evict", vc_evict_o.valid, 0);
    tick();
    check("s5_res", {l1_res_o.valid, l1_res_o.addr}, {1'b1, 32'h0000_6000});
    check("s5_res_data", l1_res_o.data, d_c3);
    check("s5_cnts", {no_probe_o, no_vc_hit_o, no_wb_o}, {32'd1, 32'd1, 32'd0});
    tick();
    check("s5_idle", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
